repeat_pattern_gen: RTL and testbench

//  Parametrised repeating-pattern source for FPGA bring-up benches and on-board stimulus.

---
 rtl/repeat_pattern_gen_pkg.sv | 25 ++
 rtl/repeat_pattern_gen_table.sv | 31 +++
 rtl/repeat_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_repeat_pattern_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/repeat_pattern_gen_pkg.sv
// Shared definitions for the repeating-pattern generator: mode encodings,
// FSM state type and a small elaboration-time helper.
package repeat_pattern_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_TABLE  = 2'd2;
  localparam logic [1:0] MODE_ROTATE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest of three values; used to size the step counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/repeat_pattern_gen_table.sv
// Pattern table for TABLE mode: DEPTH x WIDTH register file with a
// synchronous write port and an asynchronous read port. Contents are
// cleared by the asynchronous reset.
module pattern_table #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage: cleared on reset, written one entry per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/repeat_pattern_gen.sv
// Repeating-pattern source: emits TOGGLE / COUNT / TABLE / ROTATE patterns
// for a finite or infinite number of periods, qualified by valid.
// Optional feature macro: REPEAT_PATTERN_STALL_EN adds an out_ready input;
// when undefined the pattern advances once every RUN cycle.
module repeat_pattern_gen
  import repeat_pattern_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         seed,
  input  logic [CNT_W-1:0]         repeats,
  input  logic                     tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_addr,
  input  logic [WIDTH-1:0]         tbl_data,
`ifdef REPEAT_PATTERN_STALL_EN
  input  logic                     out_ready,
`endif
  output logic [WIDTH-1:0]         pattern_out,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PMAX   = max3(2 ** WIDTH, DEPTH, WIDTH);
  localparam int STEP_W = $clog2(PMAX) + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   reps_q;
  logic [CNT_W-1:0]   rep_q;
  logic [STEP_W-1:0]  step_q;
  logic [AW-1:0]      idx_q;
  logic [AW-1:0]      tbl_raddr;
  logic [WIDTH-1:0]   tbl_rd;
  logic               ready;
  logic               load;
  logic               adv;
  logic               last_step;

`ifdef REPEAT_PATTERN_STALL_EN
  assign ready = out_ready;
`else
  assign ready = 1'b1;
`endif

  // Number of values in one period of the given mode.
  function automatic logic [STEP_W-1:0] period(input logic [1:0] m);
    case (m)
      MODE_TOGGLE: return STEP_W'(2);
      MODE_COUNT:  return STEP_W'(2 ** WIDTH);
      MODE_TABLE:  return STEP_W'(DEPTH);
      default:     return STEP_W'(WIDTH);
    endcase
  endfunction

  // Pattern value that follows v in the given mode.
  function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] t);
    case (m)
      MODE_TOGGLE: return ~v;
      MODE_COUNT:  return v + 1'b1;
      MODE_TABLE:  return t;
      default:     return {v[WIDTH-2:0], v[WIDTH-1]};
    endcase
  endfunction

  // The table is read at entry 0 while idle (first TABLE value) and at the
  // next index while running; writes are locked out during a run.
  assign tbl_raddr = (state_q == ST_IDLE) ? '0 : idx_q;

  pattern_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we && (state_q == ST_IDLE)),
    .waddr (tbl_addr),
    .wdata (tbl_data),
    .raddr (tbl_raddr),
    .rdata (tbl_rd)
  );

  assign last_step = (step_q == (period(mode_q) - STEP_W'(1)));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus load/advance strobes for the datapath; stop beats advance.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          if (last_step && (reps_q != '0) && (rep_q == reps_q - 1'b1))
            state_d = ST_DONE;
          else
            adv = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pattern, step/repeat counters and latched run configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= '0;
      mode_q <= MODE_TOGGLE;
      reps_q <= '0;
      rep_q  <= '0;
      step_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      pat_q  <= (mode == MODE_TABLE) ? tbl_rd : seed;
      mode_q <= mode;
      reps_q <= repeats;
      rep_q  <= '0;
      step_q <= '0;
      idx_q  <= AW'(1);
    end else if (adv) begin
      pat_q <= next_val(mode_q, pat_q, tbl_rd);
      idx_q <= idx_q + 1'b1;
      if (last_step) begin
        step_q <= '0;
        rep_q  <= rep_q + 1'b1;
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  assign pattern_out = pat_q;
  assign valid       = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_repeat_pattern_gen.sv
// Bench for repeat_pattern_gen (WIDTH=3, DEPTH=4, CNT_W=8): directed vector
// table, hand-written corner sequences and randomized runs against a
// closed-form reference model of each pattern mode.
`timescale 1ns/1ps
module tb_repeat_pattern_gen;

  localparam int W  = 3;
  localparam int D  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [W-1:0]  seed;
  logic [CW-1:0] repeats;
  logic          tbl_we;
  logic [1:0]    tbl_addr;
  logic [W-1:0]  tbl_data;
`ifdef REPEAT_PATTERN_STALL_EN
  logic          out_ready;
`endif
  logic [W-1:0]  pattern_out;
  logic          valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  int tbl_m [D];

  typedef struct {
    int m;
    int s;
    int r;
    int n;
    int exp [8];
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen++;

  repeat_pattern_gen #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .seed        (seed),
    .repeats     (repeats),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
`ifdef REPEAT_PATTERN_STALL_EN
    .out_ready   (out_ready),
`endif
    .pattern_out (pattern_out),
    .valid       (valid),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: period length and k-th value of a run, from the mode rules.
  function automatic int period_m(input int m);
    case (m)
      0: return 2;
      1: return 1 << W;
      2: return D;
      default: return W;
    endcase
  endfunction

  function automatic int model_val(input int m, input int s, input int k);
    int r;
    case (m)
      0: return (k % 2 == 1) ? (s ^ ((1 << W) - 1)) : s;
      1: return (s + k) % (1 << W);
      2: return tbl_m[k % D];
      default: begin
        r = k % W;
        return ((s << r) | (s >> (W - r))) & ((1 << W) - 1);
      end
    endcase
  endfunction

  task automatic load_table(input int v0, input int v1, input int v2, input int v3);
    int v [D];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < D; i++) begin
      tbl_we   = 1'b1;
      tbl_addr = 2'(i);
      tbl_data = W'(v[i]);
      @(negedge clk);
      tbl_m[i] = v[i];
    end
    tbl_we = 1'b0;
  endtask

  // Pulse start for one cycle; returns at the first RUN cycle's negedge.
  task automatic begin_run(input int m, input int s, input int r);
    mode    = 2'(m);
    seed    = W'(s);
    repeats = CW'(r);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // After the last value: one DONE cycle, then idle with the value held.
  task automatic check_finish(input string name, input int last);
    check({name, " done"}, done, 1);
    check({name, " valid in DONE"}, valid, 0);
    check({name, " busy in DONE"}, busy, 1);
    check({name, " hold in DONE"}, pattern_out, last);
    @(negedge clk);
    check({name, " busy after"}, busy, 0);
    check({name, " done after"}, done, 0);
    check({name, " hold in IDLE"}, pattern_out, last);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    begin_run(v.m, v.s, v.r);
    for (int k = 0; k < v.n; k++) begin
      check({name, " valid"}, valid, 1);
      check({name, " value"}, pattern_out, v.exp[k]);
      @(negedge clk);
    end
    check_finish(name, v.exp[v.n-1]);
  endtask

  task automatic run_model(input int m, input int s, input int r, input string name);
    int n;
    n = r * period_m(m);
    begin_run(m, s, r);
    for (int k = 0; k < n; k++) begin
      check({name, " valid"}, valid, 1);
      check({name, " value"}, pattern_out, model_val(m, s, k));
      @(negedge clk);
    end
    check_finish(name, model_val(m, s, n - 1));
  endtask

  initial begin
    int d0, m, s, r, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; seed = '0;
    repeats = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
`ifdef REPEAT_PATTERN_STALL_EN
    out_ready = 1'b1;
`endif
    for (int i = 0; i < D; i++) tbl_m[i] = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset pattern_out", pattern_out, 0);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    load_table(5, 1, 3, 6);
    vecs[0] = '{0, 0, 2, 4, '{0, 7, 0, 7, 0, 0, 0, 0}};
    vecs[1] = '{1, 6, 1, 8, '{6, 7, 0, 1, 2, 3, 4, 5}};
    vecs[2] = '{3, 1, 1, 3, '{1, 2, 4, 0, 0, 0, 0, 0}};
    vecs[3] = '{3, 5, 1, 3, '{5, 3, 6, 0, 0, 0, 0, 0}};
    vecs[4] = '{2, 0, 1, 4, '{5, 1, 3, 6, 0, 0, 0, 0}};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Infinite TABLE run, table write attempted mid-run, then stop.
    d0 = done_seen;
    begin_run(2, 0, 0);
    for (int k = 0; k < 10; k++) begin
      check("inf valid", valid, 1);
      check("inf value", pattern_out, tbl_m[k % D]);
      tbl_we   = (k == 3);
      tbl_addr = '0;
      tbl_data = '0;
      @(negedge clk);
    end
    tbl_we = 1'b0;
    check("inf pre-stop value", pattern_out, 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("inf valid after stop", valid, 0);
    check("inf busy after stop", busy, 0);
    check("inf value held on stop", pattern_out, 3);
    check("inf no done pulse", done_seen, d0);

    // ROTATE with a second start (and new mode/seed) during the run.
    begin_run(3, 1, 1);
    check("rot2 v0", pattern_out, 1);
    mode = 2'd1; seed = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rot2 v1", pattern_out, 2);
    @(negedge clk);
    check("rot2 v2", pattern_out, 4);
    @(negedge clk);
    check_finish("rot2", 4);

    // start and stop together in IDLE: start wins.
    stop = 1'b1;
    begin_run(0, 2, 1);
    stop = 1'b0;
    check("startstop valid", valid, 1);
    check("startstop v0", pattern_out, 2);
    @(negedge clk);
    check("startstop v1", pattern_out, 5);
    @(negedge clk);
    check_finish("startstop", 5);

`ifdef REPEAT_PATTERN_STALL_EN
    // Stall: first value held four cycles while out_ready is low.
    out_ready = 1'b0;
    begin_run(1, 0, 1);
    for (int c = 0; c < 4; c++) begin
      check("stall valid", valid, 1);
      check("stall held", pattern_out, 0);
      if (c == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    for (int k = 1; k < 8; k++) begin
      check("stall value", pattern_out, k);
      @(negedge clk);
    end
    check_finish("stall", 7);
`endif

    // Randomized runs against the model.
    for (int it = 0; it < 16; it++) begin
      load_table($urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      r = $urandom_range(1, 3);
      run_model(m, s, r, $sformatf("rnd%0d", it));
    end
    for (int it = 0; it < 6; it++) begin
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      n = $urandom_range(1, 20);
      begin_run(m, s, 0);
      for (int k = 0; k < n; k++) begin
        check("rinf value", pattern_out, model_val(m, s, k));
        @(negedge clk);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("rinf valid after stop", valid, 0);
      check("rinf held", pattern_out, model_val(m, s, n));
    end

    // Asynchronous reset in the middle of a TABLE run.
    load_table(5, 1, 3, 6);
    begin_run(2, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst pattern_out", pattern_out, 0);
    check("midrst valid", valid, 0);
    check("midrst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < D; i++) tbl_m[i] = 0;
    @(negedge clk);
    run_model(2, 0, 1, "table cleared");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
